// File: rtl/dot_product_pkg.sv
// Shared sizes, types and output-fitting helpers for the 784-element dot product.
// Optional saturation is selected by DOTPRODUCT784_SAT_EN in the top level.
package dot_product_pkg;

    localparam int DP_LANES = 28;
    localparam int DP_BEATS = 28;
    localparam int PIX_W    = 10;
    localparam int WGT_W    = 19;
    localparam int FRAC_W   = 18;
    localparam int OUT_W    = 26;
    localparam int ACC_W    = 39;
    localparam int PROD_W   = PIX_W + WGT_W;
    localparam int SUM_W    = 34;
    localparam int CNT_W    = 5;

    typedef logic        [PIX_W-1:0]  pixel_t;
    typedef logic signed [WGT_W-1:0]  weight_t;
    typedef logic signed [PROD_W-1:0] product_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0]  result_t;
    typedef logic        [CNT_W-1:0]  beat_cnt_t;

    // Out of range exactly when the bits above the result sign disagree with it.
    function automatic result_t sat_fit(input acc_t x);
        if (x[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){x[ACC_W-1]}}) begin
            return x[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
        return x[OUT_W-1:0];
    endfunction

    function automatic result_t trunc_fit(input acc_t x);
        return x[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/dp_lane_sum28.sv
// Combinational beat sum: 28 exact pixel*weight products reduced by a balanced adder tree.
module dp_lane_sum28
    import dot_product_pkg::*;
(
    input  pixel_t  [DP_LANES-1:0] pixels,
    input  weight_t [DP_LANES-1:0] weights,
    output sum_t                   beat_sum
);

    product_t prod [DP_LANES];
    sum_t     lvl1 [14];
    sum_t     lvl2 [7];
    sum_t     lvl3 [4];
    sum_t     lvl4 [2];

    // Operands widened to the product width first so the multiply is exact.
    for (genvar gi = 0; gi < DP_LANES; gi++) begin : g_mul
        assign prod[gi] = product_t'($signed({1'b0, pixels[gi]})) * product_t'($signed(weights[gi]));
    end

    for (genvar gi = 0; gi < 14; gi++) begin : g_lvl1
        assign lvl1[gi] = sum_t'(prod[2*gi]) + sum_t'(prod[2*gi+1]);
    end

    for (genvar gi = 0; gi < 7; gi++) begin : g_lvl2
        assign lvl2[gi] = lvl1[2*gi] + lvl1[2*gi+1];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl3
        if (2*gi + 1 < 7) begin : g_pair
            assign lvl3[gi] = lvl2[2*gi] + lvl2[2*gi+1];
        end else begin : g_pass
            assign lvl3[gi] = lvl2[2*gi];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl4
        assign lvl4[gi] = lvl3[2*gi] + lvl3[2*gi+1];
    end

    assign beat_sum = lvl4[0] + lvl4[1];

endmodule

// File: rtl/dot_product_784.sv
// Streaming 784-element dot product: 28 lanes x 28 beats, result registered as Q8.18.
// Define DOTPRODUCT784_SAT_EN for a saturating result; otherwise the result wraps mod 2^26.
module dot_product_784
    import dot_product_pkg::*;
(
    input  logic                    clk,
    input  logic                    GlobalReset,
    input  logic [PIX_W-1:0]        Pixel0,
    input  logic [PIX_W-1:0]        Pixel1,
    input  logic [PIX_W-1:0]        Pixel2,
    input  logic [PIX_W-1:0]        Pixel3,
    input  logic [PIX_W-1:0]        Pixel4,
    input  logic [PIX_W-1:0]        Pixel5,
    input  logic [PIX_W-1:0]        Pixel6,
    input  logic [PIX_W-1:0]        Pixel7,
    input  logic [PIX_W-1:0]        Pixel8,
    input  logic [PIX_W-1:0]        Pixel9,
    input  logic [PIX_W-1:0]        Pixel10,
    input  logic [PIX_W-1:0]        Pixel11,
    input  logic [PIX_W-1:0]        Pixel12,
    input  logic [PIX_W-1:0]        Pixel13,
    input  logic [PIX_W-1:0]        Pixel14,
    input  logic [PIX_W-1:0]        Pixel15,
    input  logic [PIX_W-1:0]        Pixel16,
    input  logic [PIX_W-1:0]        Pixel17,
    input  logic [PIX_W-1:0]        Pixel18,
    input  logic [PIX_W-1:0]        Pixel19,
    input  logic [PIX_W-1:0]        Pixel20,
    input  logic [PIX_W-1:0]        Pixel21,
    input  logic [PIX_W-1:0]        Pixel22,
    input  logic [PIX_W-1:0]        Pixel23,
    input  logic [PIX_W-1:0]        Pixel24,
    input  logic [PIX_W-1:0]        Pixel25,
    input  logic [PIX_W-1:0]        Pixel26,
    input  logic [PIX_W-1:0]        Pixel27,
    input  logic signed [WGT_W-1:0] Weight0,
    input  logic signed [WGT_W-1:0] Weight1,
    input  logic signed [WGT_W-1:0] Weight2,
    input  logic signed [WGT_W-1:0] Weight3,
    input  logic signed [WGT_W-1:0] Weight4,
    input  logic signed [WGT_W-1:0] Weight5,
    input  logic signed [WGT_W-1:0] Weight6,
    input  logic signed [WGT_W-1:0] Weight7,
    input  logic signed [WGT_W-1:0] Weight8,
    input  logic signed [WGT_W-1:0] Weight9,
    input  logic signed [WGT_W-1:0] Weight10,
    input  logic signed [WGT_W-1:0] Weight11,
    input  logic signed [WGT_W-1:0] Weight12,
    input  logic signed [WGT_W-1:0] Weight13,
    input  logic signed [WGT_W-1:0] Weight14,
    input  logic signed [WGT_W-1:0] Weight15,
    input  logic signed [WGT_W-1:0] Weight16,
    input  logic signed [WGT_W-1:0] Weight17,
    input  logic signed [WGT_W-1:0] Weight18,
    input  logic signed [WGT_W-1:0] Weight19,
    input  logic signed [WGT_W-1:0] Weight20,
    input  logic signed [WGT_W-1:0] Weight21,
    input  logic signed [WGT_W-1:0] Weight22,
    input  logic signed [WGT_W-1:0] Weight23,
    input  logic signed [WGT_W-1:0] Weight24,
    input  logic signed [WGT_W-1:0] Weight25,
    input  logic signed [WGT_W-1:0] Weight26,
    input  logic signed [WGT_W-1:0] Weight27,
    output logic signed [OUT_W-1:0] value
);

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(DP_BEATS - 1);

    pixel_t  [DP_LANES-1:0] pixel_bus;
    weight_t [DP_LANES-1:0] weight_bus;
    sum_t                   beat_sum;

    beat_cnt_t beat_cnt_reg, beat_cnt_next;
    acc_t      acc_reg, acc_next;
    acc_t      total;
    result_t   value_reg, value_next;

    // Lane k sits at bus index k.
    assign pixel_bus = {Pixel27, Pixel26, Pixel25, Pixel24, Pixel23, Pixel22, Pixel21,
                        Pixel20, Pixel19, Pixel18, Pixel17, Pixel16, Pixel15, Pixel14,
                        Pixel13, Pixel12, Pixel11, Pixel10, Pixel9,  Pixel8,  Pixel7,
                        Pixel6,  Pixel5,  Pixel4,  Pixel3,  Pixel2,  Pixel1,  Pixel0};

    assign weight_bus = {Weight27, Weight26, Weight25, Weight24, Weight23, Weight22, Weight21,
                         Weight20, Weight19, Weight18, Weight17, Weight16, Weight15, Weight14,
                         Weight13, Weight12, Weight11, Weight10, Weight9,  Weight8,  Weight7,
                         Weight6,  Weight5,  Weight4,  Weight3,  Weight2,  Weight1,  Weight0};

    dp_lane_sum28 u_lane_sum (
        .pixels   (pixel_bus),
        .weights  (weight_bus),
        .beat_sum (beat_sum)
    );

    assign total = acc_reg + acc_t'(beat_sum);

    always_comb begin
        beat_cnt_next = beat_cnt_reg + beat_cnt_t'(1);
        acc_next      = total;
        value_next    = value_reg;
        if (beat_cnt_reg == LAST_BEAT) begin
            beat_cnt_next = '0;
            acc_next      = '0;
`ifdef DOTPRODUCT784_SAT_EN
            value_next    = sat_fit(total);
`else
            value_next    = trunc_fit(total);
`endif
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            beat_cnt_reg <= '0;
            acc_reg      <= '0;
            value_reg    <= '0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            acc_reg      <= acc_next;
            value_reg    <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: tb/tb_dot_product_784.sv
// Self-checking bench for dot_product_784: directed and random vectors against an arithmetic model.
module tb_dot_product_784;

    logic        clk;
    logic        GlobalReset;
    logic [9:0]  pix [28];
    logic [18:0] wgt [28];
    logic [25:0] value;

    int          errors = 0;
    int          checks = 0;
    logic [25:0] held   = '0;

    dot_product_784 dut (
        .clk(clk), .GlobalReset(GlobalReset),
        .Pixel0(pix[0]),   .Pixel1(pix[1]),   .Pixel2(pix[2]),   .Pixel3(pix[3]),
        .Pixel4(pix[4]),   .Pixel5(pix[5]),   .Pixel6(pix[6]),   .Pixel7(pix[7]),
        .Pixel8(pix[8]),   .Pixel9(pix[9]),   .Pixel10(pix[10]), .Pixel11(pix[11]),
        .Pixel12(pix[12]), .Pixel13(pix[13]), .Pixel14(pix[14]), .Pixel15(pix[15]),
        .Pixel16(pix[16]), .Pixel17(pix[17]), .Pixel18(pix[18]), .Pixel19(pix[19]),
        .Pixel20(pix[20]), .Pixel21(pix[21]), .Pixel22(pix[22]), .Pixel23(pix[23]),
        .Pixel24(pix[24]), .Pixel25(pix[25]), .Pixel26(pix[26]), .Pixel27(pix[27]),
        .Weight0(wgt[0]),   .Weight1(wgt[1]),   .Weight2(wgt[2]),   .Weight3(wgt[3]),
        .Weight4(wgt[4]),   .Weight5(wgt[5]),   .Weight6(wgt[6]),   .Weight7(wgt[7]),
        .Weight8(wgt[8]),   .Weight9(wgt[9]),   .Weight10(wgt[10]), .Weight11(wgt[11]),
        .Weight12(wgt[12]), .Weight13(wgt[13]), .Weight14(wgt[14]), .Weight15(wgt[15]),
        .Weight16(wgt[16]), .Weight17(wgt[17]), .Weight18(wgt[18]), .Weight19(wgt[19]),
        .Weight20(wgt[20]), .Weight21(wgt[21]), .Weight22(wgt[22]), .Weight23(wgt[23]),
        .Weight24(wgt[24]), .Weight25(wgt[25]), .Weight26(wgt[26]), .Weight27(wgt[27]),
        .value(value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q8.18 result of an exact total: clamp or wrap.
    function automatic logic [25:0] fit_model(input longint t);
`ifdef DOTPRODUCT784_SAT_EN
        if (t > 64'sd33554431)  return 26'h1FFFFFF;
        if (t < -64'sd33554432) return 26'h2000000;
`endif
        return t[25:0];
    endfunction

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%07h expected=0x%07h", tag, obs, exp);
        end
    endtask

    // Stimulus modes: 0 zero, 1 single, 2 negative, 3 pix1/w0.125, 4 max pos,
    // 5 max neg, 6 pix2/w0.125, 7 full-range random, 8 small random.
    task automatic get_stim(input int mode, input int b, input int l,
                            output logic [9:0] p, output logic [18:0] w);
        p = '0;
        w = '0;
        case (mode)
            1: if (b == 0 && l == 0) begin p = 10'd1;   w = 19'h0A196; end
            2: if (b == 0 && l == 0) begin p = 10'd100; w = 19'h40000; end
            3: begin p = 10'd1;   w = 19'h08000; end
            4: begin p = 10'd255; w = 19'h3FFFF; end
            5: begin p = 10'd255; w = 19'h40000; end
            6: begin p = 10'd2;   w = 19'h08000; end
            7: begin p = 10'($urandom_range(0, 1023)); w = 19'($urandom); end
            8: begin p = 10'($urandom_range(0, 15));   w = 19'($urandom); end
            default: ;
        endcase
    endtask

    // Drives nbeats beats; value must hold its last result on every beat,
    // and a complete vector must publish the model total right after beat 27.
    task automatic run_vector(input int mode, input int nbeats, input string tag);
        longint      total = 0;
        longint      wv;
        logic [9:0]  p;
        logic [18:0] w;
        logic [25:0] exp;
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 28; l++) begin
                get_stim(mode, b, l, p, w);
                pix[l] = p;
                wgt[l] = w;
                wv = $signed(w);
                total += longint'(p) * wv;
            end
            check({tag, "_hold"}, value, held);
            @(posedge clk);
            #1;
        end
        if (nbeats == 28) begin
            exp = fit_model(total);
            check(tag, value, exp);
            $display("vector %s mode=%0d total=%0d value=0x%07h expected=0x%07h",
                     tag, mode, total, value, exp);
            held = exp;
        end
    endtask

    initial begin
        GlobalReset = 1'b0;
        for (int l = 0; l < 28; l++) begin
            pix[l] = '0;
            wgt[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", value, 26'h0);
        @(negedge clk);
        GlobalReset = 1'b1;

        run_vector(1, 28, "single");
        check("single_const", value, 26'h000A196);
        run_vector(0, 28, "zero_after");
        check("zero_const", value, 26'h0);
        run_vector(2, 28, "negative");
        check("negative_const", value, 26'h2700000);
        run_vector(3, 28, "full_a");
        check("full_a_const", value, 26'h1880000);
        run_vector(3, 28, "full_b");
        check("full_b_const", value, 26'h1880000);

        run_vector(4, 28, "sat_pos");
`ifdef DOTPRODUCT784_SAT_EN
        check("sat_pos_const", value, 26'h1FFFFFF);
`endif
        run_vector(5, 28, "sat_neg");
`ifdef DOTPRODUCT784_SAT_EN
        check("sat_neg_const", value, 26'h2000000);
`endif

        // Reset partway through a vector: partial sum must be discarded.
        run_vector(3, 13, "pre_reset");
        GlobalReset = 1'b0;
        #1;
        check("reset_mid_async", value, 26'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_mid_held", value, 26'h0);
        held = '0;
        @(negedge clk);
        GlobalReset = 1'b1;
        run_vector(3, 28, "post_reset");
        check("post_reset_const", value, 26'h1880000);

        run_vector(6, 28, "b2b_x2_a");
        run_vector(3, 28, "b2b_x1");
        check("b2b_x1_const", value, 26'h1880000);
        run_vector(6, 28, "b2b_x2_b");
`ifdef DOTPRODUCT784_SAT_EN
        check("b2b_x2_const", value, 26'h1FFFFFF);
`else
        check("b2b_x2_const", value, 26'h3100000);
`endif

        for (int r = 0; r < 3; r++) begin
            run_vector(8, 28, "rand_small");
            run_vector(7, 28, "rand_full");
        end
        run_vector(0, 28, "zero_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
